gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_regs_pkg.sv | 22 ++
 rtl/gpio_sync.sv | 38 +++
 rtl/gpio_bank.sv | 135 +++++++++++++
 tb/tb_gpio_bank.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_regs_pkg.sv
// GPIO bank register map: word offsets and bus write-enable constant.
// Latency: n/a (constants only).
// Backpressure: n/a (no handshake; shared with firmware headers and benches).
package gpio_regs_pkg;

  // Word offsets within the block, as seen on addr[2:0].
  typedef enum logic [2:0] {
    REG_OUT_VAL = 3'd0,  // rw  output pin values
    REG_OUT_OE  = 3'd1,  // rw  output enables (0 = high-Z)
    REG_OUT_SET = 3'd2,  // w1s on OUT_VAL, reads 0
    REG_OUT_CLR = 3'd3,  // w1c on OUT_VAL, reads 0
    REG_IN      = 3'd4,  // ro  synchronised pin levels
    REG_RISE_EN = 3'd5,  // rw  rising-edge interrupt enables
    REG_FALL_EN = 3'd6,  // rw  falling-edge interrupt enables
    REG_PENDING = 3'd7   // read, w1c  latched edge events
  } gpio_reg_e;

  localparam int unsigned BUS_DW   = 32;
  // Only a full-word write is honoured; any other byte-enable mix is dropped.
  localparam logic [3:0]  WE_FULL  = 4'b1111;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop input synchroniser plus a third delay flop for edge detection.
// Latency: pin change visible on level 2-3 cycles later; rise/fall pulse same cycle as level change.
// Backpressure: none; free-running, one-cycle rise/fall pulse per transition.
//
// Ports: clk, rst_n (async active-low), din (async pins),
//        level (sync stage 2), rise (0->1 pulse), fall (1->0 pulse).
module gpio_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~dly;
  assign fall  = ~sync2 & dly;

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: output value/enable registers, synchronised inputs, edge-latched interrupt.
// Latency: writes take effect next edge; rdata 1 cycle after sel&re; irq 1 cycle after PENDING.
// Backpressure: none; the bus is always accepted, rdata holds between reads.
//
// Ports: clk, reset (async active-low), sel/addr/re/we/wdata (register bus),
//        rdata (registered read data), gpio_in (async pins),
//        gpio_out/gpio_oe (pin drive, tri-state buffer is outside), irq (level).
module gpio_bank
  import gpio_regs_pkg::*;
#(
  parameter int unsigned NUM_IN  = 1,
  parameter int unsigned NUM_OUT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sel,
  input  logic [2:0]         addr,
  input  logic               re,
  input  logic [3:0]         we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_IN-1:0]  gpio_in,
  output logic [NUM_OUT-1:0] gpio_out,
  output logic [NUM_OUT-1:0] gpio_oe,
  output logic               irq
);

  logic               wr_en;
  logic               rd_en;
  gpio_reg_e          reg_sel;
  logic [NUM_OUT-1:0] wd_out;
  logic [NUM_IN-1:0]  wd_in;

  logic [NUM_OUT-1:0] out_val;
  logic [NUM_OUT-1:0] out_oe;
  logic [NUM_IN-1:0]  rise_en;
  logic [NUM_IN-1:0]  fall_en;
  logic [NUM_IN-1:0]  pending;

  logic [NUM_IN-1:0]  in_level;
  logic [NUM_IN-1:0]  in_rise;
  logic [NUM_IN-1:0]  in_fall;
  logic [NUM_IN-1:0]  pend_set;
  logic [NUM_IN-1:0]  pend_clr;
  logic [31:0]        rd_mux;

  // Bits of wdata above the register widths are intentionally dropped.
  logic               unused_wdata;

  assign wr_en   = sel && (we == WE_FULL);
  assign rd_en   = sel && re;
  assign reg_sel = gpio_reg_e'(addr);
  assign wd_out  = wdata[NUM_OUT-1:0];
  assign wd_in   = wdata[NUM_IN-1:0];
  assign unused_wdata = ^wdata;

  gpio_sync #(
    .W (NUM_IN)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .din   (gpio_in),
    .level (in_level),
    .rise  (in_rise),
    .fall  (in_fall)
  );

  // Output value: plain write plus atomic set/clear aliases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_OUT_VAL: out_val <= wd_out;
        REG_OUT_SET: out_val <= out_val | wd_out;
        REG_OUT_CLR: out_val <= out_val & ~wd_out;
        default:     out_val <= out_val;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_oe  <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (wr_en) begin
      if (reg_sel == REG_OUT_OE)  out_oe  <= wd_out;
      if (reg_sel == REG_RISE_EN) rise_en <= wd_in;
      if (reg_sel == REG_FALL_EN) fall_en <= wd_in;
    end
  end

  // Enables sampled as they were before this edge, so an enable written in
  // the same cycle as an edge does not catch that edge. A set event and a
  // w1c on the same bit leave the bit set: set is ORed in after the clear.
  assign pend_set = (in_rise & rise_en) | (in_fall & fall_en);
  assign pend_clr = (wr_en && (reg_sel == REG_PENDING)) ? wd_in : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= (pending & ~pend_clr) | pend_set;
      irq     <= |pending;
    end
  end

  // Read mux sees register state before this edge's updates.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_OUT_VAL: rd_mux = 32'(out_val);
      REG_OUT_OE:  rd_mux = 32'(out_oe);
      REG_IN:      rd_mux = 32'(in_level);
      REG_RISE_EN: rd_mux = 32'(rise_en);
      REG_FALL_EN: rd_mux = 32'(fall_en);
      REG_PENDING: rd_mux = 32'(pending);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_mux;
    end
  end

  assign gpio_out = out_val;
  assign gpio_oe  = out_oe;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank (NUM_IN=32, NUM_OUT=4).
// Latency: reads scored one edge after issue; pins and irq checked every cycle.
// Backpressure: n/a; the bench drives the bus on falling edges, samples on falling edges.
module tb_gpio_bank;
  import gpio_regs_pkg::*;

  localparam int NI = 32;
  localparam int NO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sel = 1'b0;
  logic [2:0]    addr = '0;
  logic          re = 1'b0;
  logic [3:0]    we = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [NI-1:0] gpio_in = '1;
  logic [NO-1:0] gpio_out;
  logic [NO-1:0] gpio_oe;
  logic          irq;

  int errors = 0;
  int checks = 0;

  gpio_bank #(
    .NUM_IN  (NI),
    .NUM_OUT (NO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // smp[k] = pin vector as sampled k+1 edges ago; IN shows the value two
  // edges old, an edge event is a difference between the 2- and 3-old samples.
  logic [NO-1:0] m_out, m_oe;
  logic [NI-1:0] m_ren, m_fen, m_pend;
  logic [NI-1:0] smp [3];
  logic          m_irq;
  logic [31:0]   rd_q [$];
  bit            rd_due;
  logic [NI-1:0] m_evt, m_clr;

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    case (a)
      3'd0:    return {28'b0, m_out};
      3'd1:    return {28'b0, m_oe};
      3'd4:    return smp[1];
      3'd5:    return m_ren;
      3'd6:    return m_fen;
      3'd7:    return m_pend;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_out = '0; m_oe = '0; m_ren = '0; m_fen = '0; m_pend = '0; m_irq = 1'b0;
      for (int k = 0; k < 3; k++) smp[k] = '0;
      rd_q.delete();
      rd_due = 1'b0;
    end else begin
      rd_due = 1'b0;
      if (sel && re) begin
        rd_q.push_back(model_reg(addr));
        rd_due = 1'b1;
      end
      m_irq = (m_pend != 0);
      m_evt = ((smp[1] & ~smp[2]) & m_ren) | ((~smp[1] & smp[2]) & m_fen);
      m_clr = '0;
      if (sel && we == 4'hF) begin
        case (addr)
          3'd0: m_out = wdata[NO-1:0];
          3'd1: m_oe  = wdata[NO-1:0];
          3'd2: m_out = m_out | wdata[NO-1:0];
          3'd3: m_out = m_out & ~wdata[NO-1:0];
          3'd5: m_ren = wdata;
          3'd6: m_fen = wdata;
          3'd7: m_clr = wdata;
          default: ;
        endcase
      end
      m_pend = (m_pend & ~m_clr) | m_evt;
      smp[2] = smp[1];
      smp[1] = smp[0];
      smp[0] = gpio_in;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (rd_due) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata_scoreboard: read presented with empty queue at %0t", $time);
        end else begin
          chk("rdata", rdata, rd_q.pop_front());
        end
        rd_due = 1'b0;
      end
      chk("gpio_out", {28'b0, gpio_out}, {28'b0, m_out});
      chk("gpio_oe",  {28'b0, gpio_oe},  {28'b0, m_oe});
      chk("irq",      {31'b0, irq},      {31'b0, m_irq});
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic [2:0] a, input logic r, input logic [3:0] w, input logic [31:0] d);
    sel = 1'b1; addr = a; re = r; we = w; wdata = d;
    @(negedge clk);
    sel = 1'b0; re = 1'b0; we = '0;
  endtask

  task automatic wr(input gpio_reg_e a, input logic [31:0] d);
    op(a, 1'b0, 4'hF, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_const(input gpio_reg_e a, input logic [31:0] e, input string nm);
    op(a, 1'b1, 4'h0, 32'h0);
    chk(nm, rdata, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with inputs high.
    repeat (3) @(negedge clk);
    chk("rst_gpio_oe", {28'b0, gpio_oe}, 32'h0);
    chk("rst_gpio_out", {28'b0, gpio_out}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 1'b1;
    idle(10);
    chk("post_rst_gpio_oe", {28'b0, gpio_oe}, 32'h0);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);
    rd_const(REG_PENDING, 32'h0, "post_rst_pending");
    rd_const(REG_OUT_OE, 32'h0, "post_rst_out_oe");
    rd_const(REG_IN, 32'hFFFF_FFFF, "post_rst_in");

    // Output value, enable, set and clear aliases.
    wr(REG_OUT_VAL, 32'h5);
    chk("out_val_wr", {28'b0, gpio_out}, 32'h5);
    wr(REG_OUT_OE, 32'hF);
    chk("out_oe_wr", {28'b0, gpio_oe}, 32'hF);
    wr(REG_OUT_SET, 32'h2);
    chk("out_set", {28'b0, gpio_out}, 32'h7);
    wr(REG_OUT_CLR, 32'h4);
    chk("out_clr", {28'b0, gpio_out}, 32'h3);
    rd_const(REG_OUT_VAL, 32'h3, "rd_out_val");
    rd_const(REG_OUT_SET, 32'h0, "rd_out_set_zero");

    // Partial writes, writes to IN, and out-of-width bits are ignored.
    wr(REG_OUT_OE, 32'h0);
    op(REG_OUT_OE, 1'b0, 4'b0011, 32'hF);
    chk("partial_we", {28'b0, gpio_oe}, 32'h0);
    wr(REG_IN, 32'h0);
    rd_const(REG_IN, 32'hFFFF_FFFF, "in_ro");
    wr(REG_OUT_VAL, 32'hFFFF_FFF0);
    rd_const(REG_OUT_VAL, 32'h0, "upper_bits_dropped");

    // Rising edge on pin 0.
    gpio_in = '0;
    idle(5);
    rd_const(REG_PENDING, 32'h0, "no_evt_disabled");
    wr(REG_RISE_EN, 32'h1);
    gpio_in[0] = 1'b1;
    idle(2);
    rd_const(REG_IN, 32'h1, "in_sync_delay");
    chk("irq_lag", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    rd_const(REG_PENDING, 32'h1, "pend_rise");
    gpio_in[0] = 1'b0;
    idle(5);
    rd_const(REG_PENDING, 32'h1, "fall_not_enabled");

    // Set wins over same-cycle w1c; then a clean w1c.
    gpio_in[0] = 1'b1;
    idle(2);
    wr(REG_PENDING, 32'h1);
    chk("set_wins_irq", {31'b0, irq}, 32'h1);
    rd_const(REG_PENDING, 32'h1, "set_wins");
    wr(REG_PENDING, 32'h1);
    idle(1);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    rd_const(REG_PENDING, 32'h0, "w1c_pend");

    // Disabling enables keeps pending.
    wr(REG_FALL_EN, 32'h1);
    gpio_in[0] = 1'b0;
    idle(4);
    wr(REG_FALL_EN, 32'h0);
    wr(REG_RISE_EN, 32'h0);
    rd_const(REG_PENDING, 32'h1, "disable_keeps_pend");
    wr(REG_PENDING, 32'hFFFF_FFFF);

    // All 32 falling edges, then reset mid-transfer.
    gpio_in = '1;
    idle(4);
    wr(REG_FALL_EN, 32'hFFFF_FFFF);
    gpio_in = '0;
    idle(4);
    rd_const(REG_PENDING, 32'hFFFF_FFFF, "all_fall");
    chk("all_fall_irq", {31'b0, irq}, 32'h1);
    wr(REG_OUT_OE, 32'hF);
    sel = 1'b1; addr = 3'd0; we = 4'hF; wdata = 32'hA; re = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out", {28'b0, gpio_out}, 32'h0);
    chk("async_rst_oe", {28'b0, gpio_oe}, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    chk("async_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    sel = 1'b0; re = 1'b0; we = '0;
    reset = 1'b1;
    idle(1);
    rd_const(REG_PENDING, 32'h0, "async_rst_pend");
    rd_const(REG_FALL_EN, 32'h0, "async_rst_fall_en");

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ $urandom();
      case ($urandom_range(0, 3))
        0: idle(1);
        1: op(3'($urandom_range(0, 7)), 1'b1, 4'h0, 32'h0);
        default: op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF,
                    $urandom());
      endcase
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
